// File: rtl/midi_router_pkg.sv
// Shared constants, FSM state type and mask helper for the 4x4 MIDI router.
package midi_router_pkg;

    localparam int          NUM_PORTS   = 4;
    localparam int          MIDI_BAUD   = 31250;
    localparam logic [15:0] ROUTE_RESET = 16'hFFFF;

    typedef enum logic {
        RUN,
        PEND
    } route_state_t;

    // Input-selection mask for one output, taken from a packed route word.
    function automatic logic [NUM_PORTS-1:0] mask_slice(
        input logic [NUM_PORTS*NUM_PORTS-1:0] word,
        input int unsigned                    port
    );
        return word[NUM_PORTS*port +: NUM_PORTS];
    endfunction

endpackage

// File: rtl/midi_route_ctrl_idle.sv
// midi_idle_det: two-flop synchronizer and saturating idle counter for one MIDI input.
module midi_idle_det #(
    parameter int BIT_CLKS  = 384,
    parameter int IDLE_BITS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic line,
    output logic synced,
    output logic idle
);

    localparam int                IDLE_CLKS = IDLE_BITS * BIT_CLKS;
    localparam int                CNT_W     = $clog2(IDLE_CLKS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(IDLE_CLKS);

    logic             meta;
    logic             sync_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            sync_q <= 1'b1;
            cnt    <= '0;
        end else begin
            meta   <= line;
            sync_q <= meta;
            if (!sync_q)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    assign synced = sync_q;
    // Gated with the synced line so idle falls in the same cycle as the line.
    assign idle   = sync_q && (cnt == CNT_MAX);

endmodule

// File: rtl/midi_route_ctrl.sv
// Glitch-free MIDI route controller: commits new per-output masks only while the lines are idle.
// Optional forced commit after a timeout when MIDI_ROUTE_TIMEOUT_EN is defined.
module midi_route_ctrl
    import midi_router_pkg::*;
#(
    parameter int BIT_CLKS     = 384,
    parameter int IDLE_BITS    = 10,
    parameter int TIMEOUT_BITS = 3125
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] cfg_word,
    input  logic                           cfg_valid,
    input  logic [NUM_PORTS-1:0]           midi_in,
    output logic [NUM_PORTS-1:0]           midi_out,
    output logic [NUM_PORTS*NUM_PORTS-1:0] active_mask,
    output logic [NUM_PORTS-1:0]           pending,
    output logic [NUM_PORTS-1:0]           forced
);

    if (BIT_CLKS < 1 || IDLE_BITS < 1 || TIMEOUT_BITS < 1) begin : g_bad_params
        $error("midi_route_ctrl: timing parameters must be positive");
    end

    logic [NUM_PORTS-1:0] synced;
    logic [NUM_PORTS-1:0] idle;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        midi_idle_det #(
            .BIT_CLKS  (BIT_CLKS),
            .IDLE_BITS (IDLE_BITS)
        ) u_idle (
            .clk    (clk),
            .reset  (reset),
            .line   (midi_in[i]),
            .synced (synced[i]),
            .idle   (idle[i])
        );
    end

    // Unselected inputs are forced high so an empty mask idles the output.
    always_ff @(posedge clk) begin
        if (reset) begin
            midi_out <= '1;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++)
                midi_out[o] <= &(synced | ~mask_slice(active_mask, o));
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        route_state_t         state;
        logic [NUM_PORTS-1:0] act;
        logic [NUM_PORTS-1:0] pmask;
        logic                 pend_flag;
        logic [NUM_PORTS-1:0] new_mask;
        logic                 cfg_change;
        logic                 lines_idle;
        logic                 timeout;
        logic                 commit;

        assign new_mask   = mask_slice(cfg_word, o);
        assign cfg_change = cfg_valid && (new_mask != act);
        assign lines_idle = &(idle | ~(act | pmask));
        // A config strobe always beats a commit landing in the same cycle.
        assign commit     = (state == PEND) && !cfg_valid && (lines_idle || timeout);

        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= RUN;
                act       <= mask_slice(ROUTE_RESET, o);
                pmask     <= '0;
                pend_flag <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (cfg_change) begin
                            pmask     <= new_mask;
                            pend_flag <= 1'b1;
                            state     <= PEND;
                        end
                    end
                    PEND: begin
                        if (cfg_valid) begin
                            pmask <= new_mask;
                            if (!cfg_change) begin
                                pend_flag <= 1'b0;
                                state     <= RUN;
                            end
                        end else if (commit) begin
                            act       <= pmask;
                            pend_flag <= 1'b0;
                            state     <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end

`ifdef MIDI_ROUTE_TIMEOUT_EN
        localparam int             TO_CLKS = TIMEOUT_BITS * BIT_CLKS;
        localparam int             TO_W    = $clog2(TO_CLKS + 1);
        localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CLKS - 1);

        logic [TO_W-1:0] tcnt;
        logic            forced_flag;

        assign timeout = (state == PEND) && (tcnt == TO_LAST);

        // Restarted on every strobe; a commit without idle lines marks the output forced.
        always_ff @(posedge clk) begin
            if (reset) begin
                tcnt        <= '0;
                forced_flag <= 1'b0;
            end else begin
                if (cfg_valid || state == RUN)
                    tcnt <= '0;
                else if (!commit)
                    tcnt <= tcnt + 1'b1;

                if (cfg_valid)
                    forced_flag <= 1'b0;
                else if (commit && !lines_idle)
                    forced_flag <= 1'b1;
            end
        end

        assign forced[o] = forced_flag;
`else
        assign timeout   = 1'b0;
        assign forced[o] = 1'b0;
`endif

        assign active_mask[NUM_PORTS*o +: NUM_PORTS] = act;
        assign pending[o]                            = pend_flag;
    end

endmodule

// File: tb/tb_midi_route_ctrl.sv
// Directed testbench for midi_route_ctrl: routing table plus idle, cancel, collision and timeout sequences.
module tb_midi_route_ctrl;

    localparam int BIT_CLKS     = 4;
    localparam int IDLE_BITS    = 10;
    localparam int TIMEOUT_BITS = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cfg_word;
    logic        cfg_valid;
    logic [3:0]  midi_in;
    logic [3:0]  midi_out;
    logic [15:0] active_mask;
    logic [3:0]  pending;
    logic [3:0]  forced;

    int total = 0;
    int bad   = 0;

    midi_route_ctrl #(
        .BIT_CLKS     (BIT_CLKS),
        .IDLE_BITS    (IDLE_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_word    (cfg_word),
        .cfg_valid   (cfg_valid),
        .midi_in     (midi_in),
        .midi_out    (midi_out),
        .active_mask (active_mask),
        .pending     (pending),
        .forced      (forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  lines;
        logic [3:0]  exp_out;
    } vec_t;

    vec_t vecs [7];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] lines, input logic valid, input logic [15:0] word);
        midi_in   = lines;
        cfg_valid = valid;
        cfg_word  = word;
    endtask

    task automatic sendCfg(input logic [15:0] word);
        applyStimulus(midi_in, 1'b1, word);
        step(1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int commit_at;

        vecs[0] = '{16'h8421, 4'b1011, 4'b1011};
        vecs[1] = '{16'h0000, 4'b0000, 4'b1111};
        vecs[2] = '{16'hFFFF, 4'b1110, 4'b0000};
        vecs[3] = '{16'hFFFF, 4'b1111, 4'b1111};
        vecs[4] = '{16'h1248, 4'b0001, 4'b1000};
        vecs[5] = '{16'h3C00, 4'b0111, 4'b1011};
        vecs[6] = '{16'h00F0, 4'b1101, 4'b1101};

        // Reset with all lines low
        applyStimulus(4'h0, 1'b0, 16'h0);
        reset = 1'b1;
        step(2);
        checkOutput("reset_out", midi_out, 4'hF);
        checkOutput("reset_mask", active_mask, 16'hFFFF);
        checkOutput("reset_pending", pending, 4'h0);
        checkOutput("reset_forced", forced, 4'h0);
        reset = 1'b0;
        step(2);
        checkOutput("latency_2cyc", midi_out, 4'hF);
        step(1);
        checkOutput("latency_3cyc", midi_out, 4'h0);

        // Idle commit of a one-to-one route
        midi_in = 4'hF;
        step(50);
        sendCfg(16'h8421);
        checkOutput("idle_pending", pending, 4'hF);
        checkOutput("idle_mask_hold", active_mask, 16'hFFFF);
        step(1);
        checkOutput("idle_commit", active_mask, 16'h8421);
        checkOutput("idle_pending_clr", pending, 4'h0);
        midi_in = 4'hB;
        step(3);
        checkOutput("pulse_in2", midi_out, 4'hB);
        midi_in = 4'hF;
        step(3);

        for (int v = 0; v < 7; v++) begin
            midi_in = 4'hF;
            step(45);
            sendCfg(vecs[v].word);
            step(2);
            checkOutput($sformatf("vec%0d_mask", v), active_mask, vecs[v].word);
            midi_in = vecs[v].lines;
            step(4);
            checkOutput($sformatf("vec%0d_out", v), midi_out, vecs[v].exp_out);
        end

        // Deferred commit while input 0 keeps toggling
        midi_in = 4'hF;
        step(45);
        sendCfg(16'h8422);
        step(2);
        checkOutput("defer_start", active_mask, 16'h8422);
        for (int k = 0; k < 64; k++) begin
            applyStimulus({3'b111, ((k / 8) % 2 == 0)}, (k == 20), 16'h0001);
            step(1);
        end
        cfg_valid = 1'b0;
        checkOutput("defer_pending", pending, 4'h1);
        checkOutput("defer_partial", active_mask, 16'h0002);
        checkOutput("defer_out", midi_out, 4'hF);
        midi_in = 4'hF;
        step(42);
        checkOutput("defer_hold", active_mask, 16'h0002);
        checkOutput("defer_hold_pend", pending, 4'h1);
        step(1);
        checkOutput("defer_commit", active_mask, 16'h0001);
        checkOutput("defer_commit_pend", pending, 4'h0);

        // Cancel by resending the active word
        midi_in = 4'hE;
        step(3);
        sendCfg(16'h0002);
        checkOutput("cancel_pend_set", pending, 4'h1);
        step(5);
        sendCfg(16'h0001);
        checkOutput("cancel_pend_clr", pending, 4'h0);
        midi_in = 4'hF;
        step(45);
        checkOutput("cancel_no_change", active_mask, 16'h0001);
        midi_in = 4'hE;
        step(3);

        // Strobe landing on the commit cycle
        sendCfg(16'h0002);
        checkOutput("coll_pend_set", pending, 4'h1);
        midi_in = 4'hF;
        step(42);
        applyStimulus(4'hF, 1'b1, 16'h0004);
        step(1);
        cfg_valid = 1'b0;
        checkOutput("coll_suppressed", active_mask, 16'h0001);
        checkOutput("coll_still_pend", pending, 4'h1);
        step(1);
        checkOutput("coll_commit", active_mask, 16'h0004);
        checkOutput("coll_pend_clr", pending, 4'h0);

        // Running-status stream on input 1 that never idles
        midi_in = 4'hD;
        step(3);
        applyStimulus(4'hD, 1'b1, 16'h2222);
        step(1);
        cfg_valid = 1'b0;
        checkOutput("to_pending", pending, 4'hF);
        commit_at = -1;
        for (int k = 1; k <= 210; k++) begin
            midi_in[1] = ((k / 8) % 2 == 1);
            step(1);
            if (commit_at < 0 && active_mask == 16'h2222)
                commit_at = k;
        end
`ifdef MIDI_ROUTE_TIMEOUT_EN
        checkOutput("to_cycle", commit_at, 200);
        checkOutput("to_forced", forced, 4'hF);
        checkOutput("to_pend_clr", pending, 4'h0);
        sendCfg(16'h2222);
        checkOutput("to_forced_clr", forced, 4'h0);
`else
        checkOutput("to_no_commit", commit_at, -1);
        checkOutput("to_forced_zero", forced, 4'h0);
        checkOutput("to_still_pend", pending, 4'hF);
        checkOutput("to_mask_hold", active_mask, 16'h0004);
`endif

        // Reset discards any pending word
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checkOutput("rst_pend_clr", pending, 4'h0);
        checkOutput("rst_mask", active_mask, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_route_ctrl.md
# midi_route_ctrl

Routing controller for the 4x4 MIDI switcher. It applies a per-output input-selection mask to the merged (wired-AND) MIDI datapath. New masks arrive as 16-bit words from the SPI shift register and are committed only while every affected line is idle, so a route change never cuts or splices a UART frame. It sits between the SPI shift-register output and the `midi_out` pins, replacing the fixed all-inputs merge.

## Interface
- `BIT_CLKS`, 384: `clk` cycles per MIDI bit (12 MHz / 31250 baud).
- `IDLE_BITS`, 10: bit times a line must stay high to count as idle.
- `TIMEOUT_BITS`, 3125: bit times before a pending switch is forced (only with `MIDI_ROUTE_TIMEOUT_EN`).
- `clk  input  1`: main clock.
- `reset  input  1`: synchronous reset, active-high.
- `cfg_word  input  16`: route word. Bits `[4o+3:4o]` are the input mask for output o; bit i selects `midi_in[i]`.
- `cfg_valid  input  1`: one-cycle strobe; `cfg_word` is valid on this cycle.
- `midi_in  input  4`: asynchronous MIDI inputs, idle high.
- `midi_out  output  4`: merged MIDI outputs, registered.
- `active_mask  output  16`: route word currently applied.
- `pending  output  4`: per output, a new mask is waiting.
- `forced  output  4`: per output, the last commit was forced by timeout. Sticky.

## Operation
- Inputs pass through a 2-flop synchronizer. The synchronizer flops reset to 1.
- Per input idle detector:
  - Counter increments while the synced line is 1 and clears on 0.
  - It saturates at `IDLE_BITS*BIT_CLKS`. `idle[i]` is 1 at saturation.
  - Counter width is `clog2(IDLE_BITS*BIT_CLKS+1)`.
- `midi_out[o]` is the registered AND of synced inputs selected by `active_mask[4o+3:4o]`. An empty mask drives a constant 1.
- Per output FSM, two states:
  - **RUN**: no pending mask. On `cfg_valid`, if the new mask differs from the active mask, latch it into `pend_mask`, go to PEND, and set `pending[o]`. An identical mask is ignored.
  - **PEND**: commit when every input in (old mask | new mask) has `idle=1`. On commit, load `pend_mask` into the active mask, clear `pending[o]`, and go to RUN.
- `cfg_valid` during PEND replaces `pend_mask` and restarts the timeout. If the new mask equals the active mask, go to RUN and clear `pending[o]`.
- If `cfg_valid` and a commit condition occur in the same cycle, `cfg_valid` wins: the commit is suppressed and the new mask is evaluated from the next cycle.
- `cfg_valid` clears `forced[3:0]`.
- The four outputs commit independently.
- Reset values:
  - `midi_out=4'hF`, `active_mask=16'hFFFF` (all inputs to all outputs).
  - `pending=0`, `forced=0`.
  - All idle counters 0, all FSMs in RUN.
- Reset during PEND discards the pending mask.

## Timing
- `midi_in` to `midi_out` latency is 3 `clk` cycles: 2 synchronizer stages plus the output register.
- `cfg_valid` to `pending` rising: 1 cycle.
- Commit: the active mask updates in the cycle after the idle condition is first true. `midi_out` reflects the new mask 1 cycle later.
- A line must be high for `IDLE_BITS*BIT_CLKS` cycles after its synced value rises before `idle` asserts. For each input, `idle` drops in the same cycle its synced value falls.

## Configuration
- `MIDI_ROUTE_TIMEOUT_EN` defined:
  - A per-output counter starts on entry to PEND and restarts on each `cfg_valid`.
  - After `TIMEOUT_BITS*BIT_CLKS` cycles without a commit, the pending mask is committed anyway and `forced[o]` is set.
  - This covers continuous running-status streams that never idle.
- Undefined:
  - No timeout counters; PEND waits indefinitely.
  - `forced` is tied to 0.

## Structure
- Package `midi_router_pkg` holds:
  - `NUM_PORTS=4`, `MIDI_BAUD=31250`, `ROUTE_RESET=16'hFFFF`.
  - The FSM state typedef (RUN, PEND).
  - A mask-slice helper function.
- Sub-module `midi_idle_det`: synchronizer plus saturating idle counter for one input, instantiated 4x. The per-output FSMs are generated in the top.

## Test plan
Bench parameters: `BIT_CLKS=4`, `IDLE_BITS=10` (40-cycle idle), `TIMEOUT_BITS=50`.
- **Reset:** hold `reset` for 2 cycles with `midi_in=4'h0`. Expect `midi_out=4'hF`, `active_mask=16'hFFFF`, `pending=0`. After release, `midi_out=0` 3 cycles later.
- **Idle commit:** all inputs high for more than 40 cycles, then `cfg_valid` with `16'h8421` (output o to input o). Expect `pending=4'hF` for 1 cycle, then `active_mask=16'h8421` and `pending=0`. A pulse on `midi_in[2]` reaches only `midi_out[2]`.
- **Deferred commit:** toggle `midi_in[0]` every 8 cycles, then `cfg_valid` with `16'h0001`. Expect outputs 1-3 to commit to empty (constant 1) after idle, and `pending[0]` to stay 1. Stop the toggling: commit occurs 40 cycles after the last rise.
- **Replace/cancel:** in PEND, send `cfg_valid` with the active word. Expect `pending=0` and no mask change.
- **Collision:** `cfg_valid` lands on the exact commit cycle. Expect the new word in `pend_mask`, the old pending word never visible on `active_mask`, and the new word committed 1 cycle later.
- **Timeout:** with `MIDI_ROUTE_TIMEOUT_EN`, keep `midi_in[1]` toggling with `cfg_valid` `16'h2222`. Expect a forced commit at cycle 200 and `forced=4'hF`. Without the macro, expect no commit and `forced=0`.
